// File: rtl/shift_register.sv
// Tapped delay line: `size` words of `dataWidth` bits, shifted in at tap 0, any tap readable.
// Optional macro SHIFT_REG_REGISTERED_OUT_EN registers dout (1-cycle read latency).
module shift_register #(
  parameter int dataWidth = 16,
  parameter int size      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift,
  input  logic [dataWidth-1:0]      din,
  input  logic [$clog2(size)-1:0]   address,
  output logic [dataWidth-1:0]      dout
);

  localparam int AW = $clog2(size);

  logic [dataWidth-1:0] tap     [size];
  logic [dataWidth-1:0] tap_nxt [size];

  // Out-of-range addresses only exist for non-power-of-two depths; they read as zero.
  function automatic logic [dataWidth-1:0] read_tap(
    input logic [dataWidth-1:0] t [size],
    input logic [AW-1:0]        a
  );
    logic [dataWidth-1:0] r;
    r = '0;
    if (32'(a) < size)
      r = t[a];
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < size; i++)
      tap_nxt[i] = tap[i];
    if (rst) begin
      for (int i = 0; i < size; i++)
        tap_nxt[i] = '0;
    end else if (shift) begin
      tap_nxt[0] = din;
      for (int i = 1; i < size; i++)
        tap_nxt[i] = tap[i-1];
    end
  end

  always_ff @(posedge clk)
    tap <= tap_nxt;

`ifdef SHIFT_REG_REGISTERED_OUT_EN
  // Read stage: captures the post-edge tap contents, so a word shifted in this edge is seen.
  always_ff @(posedge clk) begin
    if (rst)
      dout <= '0;
    else
      dout <= read_tap(tap_nxt, address);
  end
`else
  always_comb
    dout = read_tap(tap, address);
`endif

endmodule

// File: tb/tb_shift_register.sv
// Directed bench for shift_register at default size (64 x 16 bits).
// Works with or without SHIFT_REG_REGISTERED_OUT_EN (reads wait one edge when registered).
module tb_shift_register;

  logic        clk = 1'b0;
  logic        rst;
  logic        shift;
  logic [15:0] din;
  logic [5:0]  address;
  logic [15:0] dout;

  int n_cmp = 0;
  int n_err = 0;

  shift_register #(.dataWidth(16), .size(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .shift   (shift),
    .din     (din),
    .address (address),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int a, input logic [15:0] exp, input string tag);
    address = 6'(a);
`ifdef SHIFT_REG_REGISTERED_OUT_EN
    step();
`else
    #1;
`endif
    chk($sformatf("%s[%0d]", tag, a), dout, exp);
  endtask

  task automatic push(input logic [15:0] v);
    din   = v;
    shift = 1'b1;
    step();
    shift = 1'b0;
  endtask

  initial begin
    rst = 1'b1; shift = 1'b0; din = '0; address = '0;

    // reset for two cycles, every tap reads zero
    step(); step();
    rst = 1'b0;
    for (int a = 0; a < 64; a++) rd(a, 16'h0000, "reset");

    // single insert
    push(16'h0001);
    rd(0, 16'h0001, "single");
    rd(1, 16'h0000, "single");

    // propagation: 5 x 0x0001 then 2 x 0xFFFF
    for (int k = 0; k < 5; k++) push(16'h0001);
    for (int k = 0; k < 2; k++) push(16'hFFFF);
    rd(0, 16'hFFFF, "prop");
    rd(1, 16'hFFFF, "prop");
    rd(2, 16'h0001, "prop");
    rd(7, 16'h0001, "prop");
    rd(8, 16'h0000, "prop");

    // hold: din changes (including unknown) while shift is low
    din = 16'h00FF;
    for (int k = 0; k < 10; k++) step();
    din = 'x;
    step();
    din = 16'h00FF;
    rd(2, 16'h0001, "hold");
    rd(0, 16'hFFFF, "hold");
    rd(8, 16'h0000, "hold");

    // overflow: 65 distinct values, oldest (1) drops out
    for (int v = 1; v <= 65; v++) push(16'(v));
    rd(0, 16'd65, "ovf");
    rd(63, 16'd2, "ovf");
    for (int a = 1; a < 63; a++) rd(a, 16'(65 - a), "ovf");

    // reset wins over shift in the same cycle
    address = 6'd5;
    rst = 1'b1; shift = 1'b1; din = 16'h1234;
    step();
    rst = 1'b0; shift = 1'b0;
    rd(0, 16'h0000, "rstpri");
    rd(63, 16'h0000, "rstpri");
    rd(5, 16'h0000, "rstpri");

    // new data after reset priority lands normally
    push(16'hA5A5);
    push(16'h5A5A);
    rd(0, 16'h5A5A, "post");
    rd(1, 16'hA5A5, "post");
    rd(2, 16'h0000, "post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
